otp_nibble_xor: RTL
===================

// Module: otp_nibble_xor
// PURPOSE
//  Downstream stage of the message nibble shifter. Consumes the 4-bit nibble stream (MSB nibble first), XORs each
//  nibble with the matching key nibble, and reassembles the full-width cipher word. Emits a one-cycle done pulse.
//  The same block decrypts: feeding it cipher nibbles with the same key yields the plaintext.
// PARAMETERS
//  MSG_W   `MSG_SIZE (constants.vh)   message/key width in bits; must be a multiple of 4 and >= 8
//  NIB     MSG_W/4 (localparam)       nibbles per message
//  CNT_W   $clog2(NIB) (localparam)   nibble counter width
// PORTS
//  clk        in   1      single system clock, all logic on posedge
//  rst_n      in   1      synchronous, active-low reset
//  start      in   1      begin new message; latches key_in
//  key_in     in   MSG_W  one-time-pad key, sampled only on the accepted start
//  nib_valid  in   1      nib_in holds a new nibble this cycle
//  nib_in     in   4      message nibble from the shifter, MSB nibble first
//  busy       out  1      high in RUN
//  done       out  1      one-cycle pulse: cipher_out just updated
//  cipher_out out  MSG_W  last completed result, held until the next completion
//  nib_cnt    out  CNT_W  nibbles accepted in the current message
//  key_reuse  out  1      sticky flag, see CONFIGURATION
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; busy=0, done=0, cipher_out=0, nib_cnt=0, key_reuse=0; key/acc cleared.
//   Reset wins over every other input, including mid-message; a partial result is discarded.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: nib_valid is ignored. start=1 -> key_sr<=key_in, acc<=0, nib_cnt<=0, go to RUN (busy=1 next cycle).
//   RUN:  nib_valid=1 -> acc<={acc[MSG_W-5:0], nib_in ^ key_sr[MSG_W-1 -: 4]}, key_sr<<=4, nib_cnt++.
//         nib_valid=0 -> hold everything. Gaps are unlimited.
//         On the edge that accepts nibble NIB-1: cipher_out<=final acc value (including this nibble), go to DONE.
//   DONE: done=1 for exactly this cycle, busy=0; next state IDLE. Also accepts start (same action as in IDLE).
//  start in RUN: abort and restart. Key is reloaded and acc/nib_cnt are cleared. nib_valid in that cycle is dropped.
//   No done pulse; cipher_out is unchanged.
//  Latency: done is high in the cycle after the edge that samples the last nibble.
//   Minimum start-to-done is NIB+1 cycles (start edge, NIB valid edges, then done cycle).
//  nib_cnt wraps to 0 on entry to DONE. cipher_out changes only on a completion edge or reset.
//  Pure bitwise XOR, no carries. Bit order: first nibble received maps to cipher_out[MSG_W-1:MSG_W-4].
// CONFIGURATION
//  OTP_KEY_REUSE_EN defined: a prev_key register (reset 0, valid flag reset 0) stores the key of each accepted start.
//   If the next accepted start presents key_in == prev_key while the valid flag is set, key_reuse<=1.
//   key_reuse stays 1 until rst_n. Detection does not alter the datapath.
//  OTP_KEY_REUSE_EN undefined: no prev_key storage; key_reuse is tied to 0.
// TESTING (MSG_W=16)
//  1 start with key 0x0F0F; nibbles A,5,C,3 on consecutive cycles
//    -> done one cycle after the 4th nibble, cipher_out=0xAACC, busy low in the done cycle.
//  2 Same as 1 with nib_valid gaps of 0-3 random cycles
//    -> cipher_out=0xAACC; done only after the 4th valid nibble; nib_cnt tracks 1,2,3 then 0.
//  3 Feed 0xAACC nibbles with key 0x0F0F
//    -> cipher_out=0xA5C3 (decrypt symmetry); nib_valid in IDLE beforehand has no effect.
//  4 After 2 nibbles, start with key 0xFFFF, then send 1,2,3,4
//    -> no done after the abort, then cipher_out=0xEDCB; start asserted in the DONE cycle is accepted.
//  5 rst_n=0 for one edge after 3 nibbles
//    -> all outputs 0 next cycle; the following full message completes correctly.
//  6 OTP_KEY_REUSE_EN: two messages both keyed 0x1234 -> key_reuse=1 at the 2nd start edge and stays 1.
//    Macro off -> key_reuse stays 0.

Source files
------------

// File: rtl/otp_nibble_xor.sv
// One-time-pad nibble XOR stage: XORs a MSB-first nibble stream with a latched key and rebuilds the cipher word.
// Build option: define OTP_KEY_REUSE_EN to add the sticky key-reuse detector (otherwise key_reuse is tied low).
module otp_nibble_xor #(
    parameter int MSG_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [MSG_W-1:0]              key_in,
    input  logic                          nib_valid,
    input  logic [3:0]                    nib_in,
    output logic                          busy,
    output logic                          done,
    output logic [MSG_W-1:0]              cipher_out,
    output logic [$clog2(MSG_W/4)-1:0]    nib_cnt,
    output logic                          key_reuse
);
    // state | meaning
    // IDLE  | waiting for start, nibbles ignored
    // RUN   | accepting nibbles, busy high
    // DONE  | single-cycle done pulse, start still accepted
    localparam int NIB   = MSG_W / 4;
    localparam int CNT_W = $clog2(NIB);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [MSG_W-1:0] key_sr;
    logic [MSG_W-1:0] acc;
    logic [MSG_W-1:0] acc_nxt;
    logic [3:0]       nib_x;
    logic             last_nib;

    always_comb begin
        nib_x    = nib_in ^ key_sr[MSG_W-1 -: 4];
        acc_nxt  = {acc[MSG_W-5:0], nib_x};
        last_nib = (nib_cnt == CNT_W'(NIB - 1));
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    // start is honoured in every state; in RUN it aborts the partial message
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            key_sr     <= '0;
            acc        <= '0;
            nib_cnt    <= '0;
            cipher_out <= '0;
        end else if (start) begin
            state   <= ST_RUN;
            key_sr  <= key_in;
            acc     <= '0;
            nib_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (nib_valid) begin
                        acc    <= acc_nxt;
                        key_sr <= {key_sr[MSG_W-5:0], 4'h0};
                        if (last_nib) begin
                            cipher_out <= acc_nxt;
                            nib_cnt    <= '0;
                            state      <= ST_DONE;
                        end else begin
                            nib_cnt <= nib_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef OTP_KEY_REUSE_EN
    logic [MSG_W-1:0] prev_key;
    logic             prev_key_vld;
    logic             key_reuse_q;

    // observation only; never feeds back into the datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_key     <= '0;
            prev_key_vld <= 1'b0;
            key_reuse_q  <= 1'b0;
        end else if (start) begin
            if (prev_key_vld && (key_in == prev_key))
                key_reuse_q <= 1'b1;
            prev_key     <= key_in;
            prev_key_vld <= 1'b1;
        end
    end

    assign key_reuse = key_reuse_q;
`else
    assign key_reuse = 1'b0;
`endif

endmodule
